rle_serial_tx: RTL and testbench
================================

Name: rle_serial_tx

Overview:
Parametrised run-length encoder with a serial line transmitter. It accepts pixel samples (colour plus end-of-line flag) from a producer over a dav_/rfd handshake and accumulates runs of equal colour. For each run it emits one asynchronous-style serial frame on txd containing the colour and the run length. It sits between the pixel source and the serial line and generalises the single-bit, fixed-format run encoder to configurable colour width, count width, parity, stop bits and bit time.

Parameters:
CW, 1, colour width in bits (1..8)
NW, 7, run-count width in bits (2..12)
PARITY, 0, parity mode: 0 none, 1 even, 2 odd (computed over colour and count bits)
STOP_BITS, 1, number of stop bits (1 or 2)
CLKS_PER_BIT, 1, clock periods per serial bit (1..255)

Ports:
clock  in  1  system clock, all state on rising edge
reset_  in  1  asynchronous, active-low reset
dav_  in  1  data valid from producer, active low
colore  in  CW  pixel colour, stable while dav_=0
endline  in  1  end-of-line marker, qualified by dav_=0
rfd  out  1  ready for data, to producer
txd  out  1  serial line, idle at mark (1)
busy  out  1  frame pending or being shifted

Behaviour:
- Reset (asynchronous, reset_=0): rfd=1, txd=1, busy=0, run colour B=0, run count N=0 (run empty), shifter and bit timer cleared. Reset during a frame aborts it immediately: txd=1, and nothing resumes after release.
- Handshake: sample taken at the edge where rfd=1 and dav_=0. rfd=0 from the next edge. No further sample until dav_ is seen high and all frames triggered by the sample have completed their last stop bit. rfd returns to 1 on the edge after both conditions hold. If dav_ stays low indefinitely, the block waits and never double-samples.
- Sample with endline=0, colour c:
  - N=0: B<=c, N<=1, no frame.
  - c==B and N<2^NW-2: N<=N+1, no frame.
  - c==B and N==2^NW-2: N reaches max 2^NW-1. Emit frame (B, max) and set N<=0, B kept. A following same-colour sample starts a fresh run N=1.
  - c!=B, N>0: emit frame (B,N), then B<=c, N<=1.
- Sample with endline=1: colore is ignored (carries no pixel). If N>0, emit frame (B,N). Then emit the EOL frame (all payload bits 0). Then N<=0, B<=0. An EOL with an empty run emits the EOL frame only.
- N=0 never appears in a data frame, so a zero count uniquely marks EOL.
- Frame, bits sent LSB first:
  - start bit 0
  - colour bits B[0..CW-1]
  - count bits N[0..NW-1]
  - parity bit, if PARITY!=0
  - STOP_BITS ones
- Frame length F = 1+CW+NW+(PARITY!=0)+STOP_BITS bits. Each bit is held exactly CLKS_PER_BIT clocks.
- Parity: even mode makes the total number of ones over colour+count+parity even. Odd mode makes it odd.
- Latency: sample at edge k, start bit on txd from edge k+1.
- Two frames from one sample (flush + EOL) go back-to-back: the second start bit immediately follows the last stop bit, with no idle cycle.
- After the last stop bit, txd stays 1.
- busy=1 from edge k+1 until the edge ending the last stop bit of the last pending frame.
- Control FSM states: IDLE (rfd=1), EVAL (update run, decide frames), SHIFT (frame out), WAIT_DAV (rfd=0 until dav_=1).
  - Transitions: IDLE->EVAL on sample.
  - EVAL->SHIFT if a frame is pending, else EVAL->WAIT_DAV.
  - SHIFT->SHIFT while a second frame is pending, then SHIFT->WAIT_DAV.
  - WAIT_DAV->IDLE when dav_=1.
- Internal counters are sized to parameters. The bit-timer wraps only via an explicit reload, never by overflow.

Test Plan:
1. Reset: assert reset_=0 mid-operation -> rfd=1, txd=1, busy=0 asynchronously. After release, the first sample starts a fresh run with no frame.
2. Defaults (CW=1, NW=7, no parity, 1 stop, CLKS_PER_BIT=1). Samples colour 1,1,1,0 -> on the 4th sample txd sends 0,1,1,1,0,0,0,0,0,1 (B=1, N=3), one bit per clock from edge k+1. rfd=0 throughout.
3. Defaults, run of two 0s then endline=1 -> frame 0,0,0,1,0,0,0,0,0,1 followed with no gap by EOL frame 0,0,0,0,0,0,0,0,0,1. busy=1 for 20 clocks. rfd stays 0 until the 20th stop bit ends and dav_=1.
4. Saturation with NW=3: seven samples of colour 1 -> frame on the 7th sample with N=7 (bits 0,1,1,1,1,1). The 8th sample of colour 1 produces no frame and sets N=1.
5. CW=2, NW=4, PARITY=1, STOP_BITS=2, CLKS_PER_BIT=4: three samples of 2'b10, then 2'b01 -> bits 0,0,1,1,1,0,0,1,1,1, each held 4 clocks (40 clocks total). The parity bit is 1 because the payload contains 3 ones.
6. Handshake abuse: hold dav_=0 for 50 clocks after a sample -> exactly one sample taken. rfd rises one edge after dav_=1 once the frame is done. An EOL with empty run -> EOL frame only.

Source files
------------

// File: rtl/rle_serial_tx.sv
// rle_serial_tx: run-length encoder with an async-style serial framer.
// Ports: clock, reset_ (async, active low); dav_/rfd pixel handshake;
//   colore/endline pixel in; txd serial out (idles at 1); busy = frame out.
module rle_serial_tx #(
  parameter int CW           = 1,
  parameter int NW           = 7,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          dav_,
  input  logic [CW-1:0] colore,
  input  logic          endline,
  output logic          rfd,
  output logic          txd,
  output logic          busy
);

  localparam int PB  = (PARITY != 0) ? 1 : 0;
  localparam int FW  = 1 + CW + NW + PB + STOP_BITS;
  localparam int BCW = $clog2(FW + 1);
  localparam int TW  = (CLKS_PER_BIT > 1) ?
                       $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TW-1:0]  T_RLD = TW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] B_RLD = BCW'(FW);
  localparam logic [BCW-1:0] B_ONE = BCW'(1);
  // one below the saturated count
  localparam logic [NW-1:0]  N_PRE = {{(NW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    SHIFT,
    WAIT_DAV
  } state_t;

  // frame image, LSB first on the line; upper bits are stop ones
  function automatic logic [FW-1:0] frame(
    input logic [CW-1:0] b,
    input logic [NW-1:0] n
  );
    logic [FW-1:0] f;
    f               = '1;
    f[0]            = 1'b0;
    f[CW:1]         = b;
    f[CW+NW:CW+1]   = n;
    if (PB != 0) begin
      f[CW+NW+1] = (PARITY == 2) ? ~^{b, n} : ^{b, n};
    end
    return f;
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic           eol_q, eol_d;
  logic [CW-1:0]  b_q, b_d;
  logic [NW-1:0]  n_q, n_d;
  logic [FW-1:0]  sr_q, sr_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           pend_q, pend_d;
  logic           go;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      col_q   <= '0;
      eol_q   <= 1'b0;
      b_q     <= '0;
      n_q     <= '0;
      sr_q    <= '1;
      bcnt_q  <= '0;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      eol_q   <= eol_d;
      b_q     <= b_d;
      n_q     <= n_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    eol_d   = eol_q;
    b_d     = b_q;
    n_d     = n_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    tmr_d   = tmr_q;
    pend_d  = pend_q;
    go      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!dav_) begin
          col_d   = colore;
          eol_d   = endline;
          state_d = EVAL;
        end
      end
      EVAL: begin
        state_d = WAIT_DAV;
        if (eol_q) begin
          // flush the open run first, EOL frame queued behind it
          go  = 1'b1;
          n_d = '0;
          b_d = '0;
          if (n_q != '0) begin
            sr_d   = frame(b_q, n_q);
            pend_d = 1'b1;
          end else begin
            sr_d = frame({CW{1'b0}}, {NW{1'b0}});
          end
        end else if (n_q == '0) begin
          b_d = col_q;
          n_d = NW'(1);
        end else if (col_q == b_q) begin
          if (n_q == N_PRE) begin
            go   = 1'b1;
            sr_d = frame(b_q, '1);
            n_d  = '0;
          end else begin
            n_d = n_q + 1'b1;
          end
        end else begin
          go   = 1'b1;
          sr_d = frame(b_q, n_q);
          b_d  = col_q;
          n_d  = NW'(1);
        end
        if (go) begin
          state_d = SHIFT;
          tmr_d   = T_RLD;
          bcnt_d  = B_RLD;
        end
      end
      SHIFT: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (bcnt_q != B_ONE) begin
          sr_d   = {1'b1, sr_q[FW-1:1]};
          bcnt_d = bcnt_q - 1'b1;
          tmr_d  = T_RLD;
        end else if (pend_q) begin
          // back-to-back EOL frame, no idle bit
          sr_d   = frame({CW{1'b0}}, {NW{1'b0}});
          pend_d = 1'b0;
          bcnt_d = B_RLD;
          tmr_d  = T_RLD;
        end else begin
          sr_d    = '1;
          state_d = WAIT_DAV;
        end
      end
      WAIT_DAV: begin
        if (dav_) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rfd  = (state_q == IDLE);
  assign busy = (state_q == SHIFT);
  assign txd  = sr_q[0];

endmodule

// File: tb/tb_rle_serial_tx.sv
// tb_rle_serial_tx: three differently configured encoders on one stimulus,
//   frame scoreboard per instance fed by a run-length reference model.
module tb_rle_serial_tx;

  localparam int C0_CW = 1, C0_NW = 7, C0_PAR = 0, C0_ST = 1, C0_CPB = 1;
  localparam int C1_CW = 2, C1_NW = 3, C1_PAR = 1, C1_ST = 2, C1_CPB = 3;
  localparam int C2_CW = 3, C2_NW = 4, C2_PAR = 2, C2_ST = 1, C2_CPB = 2;

  int pcw[3]   = '{C0_CW, C1_CW, C2_CW};
  int pnw[3]   = '{C0_NW, C1_NW, C2_NW};
  int ppar[3]  = '{C0_PAR, C1_PAR, C2_PAR};
  int pst[3]   = '{C0_ST, C1_ST, C2_ST};
  int pcpb[3]  = '{C0_CPB, C1_CPB, C2_CPB};

  logic       clk = 1'b0;
  logic       reset_ = 1'b1;
  logic       dav_ = 1'b1;
  logic       endline = 1'b0;
  logic [7:0] col = 8'd0;
  wire  [2:0] rfd_w, txd_w, busy_w;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rle_serial_tx #(.CW(C0_CW), .NW(C0_NW), .PARITY(C0_PAR),
    .STOP_BITS(C0_ST), .CLKS_PER_BIT(C0_CPB)) u0 (
    .clock(clk), .reset_(reset_), .dav_(dav_), .colore(col[0:0]),
    .endline(endline), .rfd(rfd_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));

  rle_serial_tx #(.CW(C1_CW), .NW(C1_NW), .PARITY(C1_PAR),
    .STOP_BITS(C1_ST), .CLKS_PER_BIT(C1_CPB)) u1 (
    .clock(clk), .reset_(reset_), .dav_(dav_), .colore(col[1:0]),
    .endline(endline), .rfd(rfd_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));

  rle_serial_tx #(.CW(C2_CW), .NW(C2_NW), .PARITY(C2_PAR),
    .STOP_BITS(C2_ST), .CLKS_PER_BIT(C2_CPB)) u2 (
    .clock(clk), .reset_(reset_), .dav_(dav_), .colore(col[2:0]),
    .endline(endline), .rfd(rfd_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));

  typedef struct {
    logic [31:0] bits;
    int          start;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   mb[3], mn[3];
  int   n_chk = 0, n_fail = 0;

  function automatic void chk(string nm, int id,
                              logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst %0d cycle %0d: got %0d want %0d",
               nm, id, cyc, got, want);
    end
  endfunction

  function automatic exp_t ent(logic [31:0] b, int s);
    exp_t e;
    e.bits  = b;
    e.start = s;
    return e;
  endfunction

  function automatic void qpush(int id, exp_t e);
    if (id == 0) q0.push_back(e);
    else if (id == 1) q1.push_back(e);
    else q2.push_back(e);
  endfunction

  function automatic exp_t qpop(int id);
    if (id == 0) return q0.pop_front();
    else if (id == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  function automatic int qsz(int id);
    if (id == 0) return q0.size();
    else if (id == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic int fw(int id);
    return 1 + pcw[id] + pnw[id] + (ppar[id] != 0 ? 1 : 0) + pst[id];
  endfunction

  // line image of one frame: start, colour, count, parity, stop ones
  function automatic logic [31:0] mk(int id, int b, int n);
    logic [31:0] v;
    int p, ones;
    v = '1;
    v[0] = 1'b0;
    p = 1;
    ones = 0;
    for (int i = 0; i < pcw[id]; i++) begin
      v[p] = ((b >> i) & 1) != 0;
      ones += (b >> i) & 1;
      p++;
    end
    for (int i = 0; i < pnw[id]; i++) begin
      v[p] = ((n >> i) & 1) != 0;
      ones += (n >> i) & 1;
      p++;
    end
    if (ppar[id] == 1) v[p] = (ones % 2) == 1;
    if (ppar[id] == 2) v[p] = (ones % 2) == 0;
    return v;
  endfunction

  // reference run-length model; returns the cycle the block is free
  task automatic mdl(input int id, input int c, input bit eol,
                     input int k, output int w);
    int cm, mx, l, st;
    cm = c & ((1 << pcw[id]) - 1);
    mx = (1 << pnw[id]) - 1;
    l  = fw(id) * pcpb[id];
    st = k + 1;
    if (eol) begin
      if (mn[id] > 0) begin
        qpush(id, ent(mk(id, mb[id], mn[id]), st));
        st += l;
      end
      qpush(id, ent(mk(id, 0, 0), st));
      st += l;
      mn[id] = 0;
      mb[id] = 0;
    end else if (mn[id] == 0) begin
      mb[id] = cm;
      mn[id] = 1;
    end else if (cm == mb[id]) begin
      mn[id]++;
      if (mn[id] == mx) begin
        qpush(id, ent(mk(id, mb[id], mn[id]), st));
        st += l;
        mn[id] = 0;
      end
    end else begin
      qpush(id, ent(mk(id, mb[id], mn[id]), st));
      st += l;
      mb[id] = cm;
      mn[id] = 1;
    end
    w = st;
  endtask

  // one handshake; caller is at a negedge with every rfd high
  task automatic send(input int c, input bit eol, input int hold,
                      input bit wt);
    int k, d, rmax;
    int w[3], r[3];
    dav_ = 1'b0;
    col = c[7:0];
    endline = eol;
    @(negedge clk);
    k = cyc;
    for (int id = 0; id < 3; id++) mdl(id, c, eol, k, w[id]);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      for (int id = 0; id < 3; id++) chk("rfd_hold", id, rfd_w[id], 0);
    end
    dav_ = 1'b1;
    col = 8'($urandom);
    endline = 1'($urandom);
    d = cyc;
    rmax = 0;
    for (int id = 0; id < 3; id++) begin
      r[id] = ((w[id] > d) ? w[id] : d) + 1;
      if (r[id] > rmax) rmax = r[id];
    end
    if (wt) begin
      forever begin
        for (int id = 0; id < 3; id++)
          chk("rfd", id, rfd_w[id], (cyc >= r[id]) ? 1 : 0);
        if (cyc >= rmax) break;
        @(negedge clk);
      end
    end
  endtask

  task automatic mon(input int id);
    exp_t e;
    int l, bad, nb;
    bit have, ab;
    l = fw(id) * pcpb[id];
    forever begin
      @(negedge clk);
      if (reset_ && txd_w[id] == 1'b0) begin
        have = qsz(id) > 0;
        if (have) begin
          e = qpop(id);
          chk("start_cycle", id, cyc, e.start);
        end else begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame inst %0d cycle %0d: got start bit want idle",
                   id, cyc);
          e = ent('1, 0);
        end
        bad = 0;
        nb = 0;
        ab = 0;
        for (int i = 0; i < l; i++) begin
          if (i > 0) @(negedge clk);
          if (!reset_) begin
            ab = 1;
            break;
          end
          if (txd_w[id] !== e.bits[i / pcpb[id]]) bad++;
          if (busy_w[id] !== 1'b1) nb++;
        end
        if (have && !ab) begin
          chk("frame_bits_wrong", id, bad, 0);
          chk("frame_busy_low", id, nb, 0);
        end
      end else begin
        chk("idle_busy", id, busy_w[id], 0);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  initial begin
    int c;
    bit e;
    int h;
    for (int id = 0; id < 3; id++) begin
      mb[id] = 0;
      mn[id] = 0;
    end
    #1 reset_ = 1'b0;
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      chk("rst_rfd", id, rfd_w[id], 1);
      chk("rst_txd", id, txd_w[id], 1);
      chk("rst_busy", id, busy_w[id], 0);
    end
    reset_ = 1'b1;
    @(negedge clk);

    // run 1,1,1 then 0; run 0,0 then EOL; EOL on empty run
    send(1, 0, 0, 1); send(1, 0, 0, 1); send(1, 0, 0, 1);
    send(0, 0, 0, 1); send(0, 0, 0, 1);
    send(3, 1, 0, 1);
    send(0, 1, 0, 1);
    // saturation of the narrow counters, then a fresh run
    repeat (8) send(1, 0, 0, 1);
    send(0, 1, 0, 1);
    repeat (3) send(2, 0, 0, 1);
    send(1, 0, 0, 1);
    // dav_ held low long after a sample
    send(3, 0, 50, 1);
    send(3, 0, 0, 1);
    send(1, 1, 3, 1);
    // long run saturates even the wide counter
    repeat (130) send(5, 0, 0, 1);
    send(0, 1, 0, 1);

    // reset in the middle of a frame
    send(3, 0, 0, 1);
    send(4, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2 reset_ = 1'b0;
    #1;
    for (int id = 0; id < 3; id++) begin
      chk("async_rfd", id, rfd_w[id], 1);
      chk("async_txd", id, txd_w[id], 1);
      chk("async_busy", id, busy_w[id], 0);
    end
    q0.delete(); q1.delete(); q2.delete();
    for (int id = 0; id < 3; id++) begin
      mb[id] = 0;
      mn[id] = 0;
    end
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    for (int id = 0; id < 3; id++) chk("post_rst_rfd", id, rfd_w[id], 1);
    send(7, 0, 0, 1);
    send(0, 0, 0, 1);
    send(0, 1, 0, 1);

    // random runs
    c = 0;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) c = $urandom_range(0, 7);
      e = ($urandom_range(0, 11) == 0);
      h = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      send(c, e, h, 1);
    end
    send(c, 1, 0, 1);

    for (int i = 0; i < 200; i++) begin
      if (qsz(0) + qsz(1) + qsz(2) == 0 && busy_w == 3'b000) break;
      @(negedge clk);
    end
    for (int id = 0; id < 3; id++) chk("drain", id, qsz(id), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
